// File: rtl/pll_reset_sequencer.sv
// pll_reset_sequencer
//   Supervises an ECP5 EHXPLLL from its reference clock. It pulses the PLL
//   reset, qualifies LOCK through a 2-FF synchroniser and a consecutive-cycle
//   filter, and then releases the per-domain resets one at a time, starting
//   with bit 0. If lock is lost in RELEASE or RUN, every domain goes back into
//   reset, the loss is counted, and the sequence starts again.
//
//   Optional feature: define RSTSEQ_WATCHDOG_EN to re-pulse the PLL reset when
//   WAIT_LOCK runs for LOCK_TIMEOUT cycles without seeing lock.
//
// Ports
//   clkin         in   reference clock; the only clock in this block
//   resetn        in   asynchronous active-low reset
//   locked_in     in   PLL LOCK (asynchronous; synchronised internally)
//   soft_req      in   single-cycle request to re-sequence the domains without
//                      resetting the PLL (honoured only in RUN)
//   pll_rst       out  EHXPLLL RST, active-high
//   domain_rst    out  per-domain active-high resets; bit 0 is released first
//   all_ready     out  high when every domain is out of reset
//   relock_count  out  number of lock-loss events, saturating at 255
//   state         out  FSM state for debug (0..4)
module pll_reset_sequencer #(
  parameter int unsigned NUM_DOMAINS    = 4,
  parameter int unsigned PLL_RST_CYCLES = 16,
  parameter int unsigned LOCK_FILTER    = 1024,
  parameter int unsigned STAGE_DELAY    = 256,
  parameter int unsigned LOCK_TIMEOUT   = 1048576,
  parameter int unsigned CNT_W          = 21
) (
  input  logic                   clkin,
  input  logic                   resetn,
  input  logic                   locked_in,
  input  logic                   soft_req,
  output logic                   pll_rst,
  output logic [NUM_DOMAINS-1:0] domain_rst,
  output logic                   all_ready,
  output logic [7:0]             relock_count,
  output logic [2:0]             state
);

  localparam int unsigned IDX_W = (NUM_DOMAINS > 1) ? $clog2(NUM_DOMAINS) : 1;

  localparam logic [CNT_W-1:0] PLL_LAST     = CNT_W'(PLL_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] FILTER_LAST  = CNT_W'(LOCK_FILTER - 1);
  localparam logic [CNT_W-1:0] STAGE_LAST   = CNT_W'(STAGE_DELAY - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [IDX_W-1:0] LAST_IDX     = IDX_W'(NUM_DOMAINS - 1);

  typedef enum logic [2:0] {
    PLLRST    = 3'd0,
    WAIT_LOCK = 3'd1,
    FILTER    = 3'd2,
    RELEASE   = 3'd3,
    RUN       = 3'd4
  } stateT;

  stateT             stateQ;
  logic [CNT_W-1:0]  cnt;
  logic [IDX_W-1:0]  idx;
  logic              lockMeta;
  logic              lockSync;
  logic              lostLock;

  // Lock loss overrides every other action in RELEASE and RUN, including a
  // soft_req that arrives in the same cycle.
  assign lostLock = !lockSync && (stateQ == RELEASE || stateQ == RUN);
  assign state    = stateQ;

  always_ff @(posedge clkin or negedge resetn) begin
    if (!resetn) begin
      stateQ       <= PLLRST;
      cnt          <= '0;
      idx          <= '0;
      lockMeta     <= 1'b0;
      lockSync     <= 1'b0;
      pll_rst      <= 1'b1;
      domain_rst   <= '1;
      all_ready    <= 1'b0;
      relock_count <= '0;
    end else begin
      lockMeta <= locked_in;
      lockSync <= lockMeta;

      if (lostLock) begin
        domain_rst <= '1;
        all_ready  <= 1'b0;
        if (relock_count != 8'hFF) relock_count <= relock_count + 8'd1;
        stateQ <= WAIT_LOCK;
        cnt    <= '0;
        idx    <= '0;
      end else begin
        case (stateQ)
          PLLRST: begin
            pll_rst <= 1'b1;
            if (cnt == PLL_LAST) begin
              pll_rst <= 1'b0;
              stateQ  <= WAIT_LOCK;
              cnt     <= '0;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end

          WAIT_LOCK: begin
            if (lockSync) begin
              stateQ <= FILTER;
              cnt    <= '0;
`ifdef RSTSEQ_WATCHDOG_EN
            end else if (cnt == TIMEOUT_LAST) begin
              stateQ  <= PLLRST;
              pll_rst <= 1'b1;
              cnt     <= '0;
            end else begin
              cnt <= cnt + 1'b1;
            end
`else
            // Without the watchdog the counter only parks at the timeout
            // value; it never causes a transition.
            end else if (cnt != TIMEOUT_LAST) begin
              cnt <= cnt + 1'b1;
            end
`endif
          end

          FILTER: begin
            if (!lockSync) begin
              stateQ <= WAIT_LOCK;
              cnt    <= '0;
            end else if (cnt == FILTER_LAST) begin
              stateQ <= RELEASE;
              cnt    <= '0;
              idx    <= '0;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end

          RELEASE: begin
            if (cnt == STAGE_LAST) begin
              cnt             <= '0;
              domain_rst[idx] <= 1'b0;
              if (idx == LAST_IDX) stateQ <= RUN;
              else                 idx    <= idx + 1'b1;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end

          RUN: begin
            if (soft_req) begin
              domain_rst <= '1;
              all_ready  <= 1'b0;
              stateQ     <= RELEASE;
              cnt        <= '0;
              idx        <= '0;
            end else begin
              // domain_rst is already all-zero on RUN entry, so this asserts
              // one cycle after the last release.
              all_ready <= 1'b1;
            end
          end

          default: begin
            stateQ     <= PLLRST;
            pll_rst    <= 1'b1;
            domain_rst <= '1;
            all_ready  <= 1'b0;
            cnt        <= '0;
            idx        <= '0;
          end
        endcase
      end
    end
  end

endmodule
